// File: rtl/cdb_pkg.sv
// Shared types and constants for the CDB writeback slice.
package cdb_pkg;

  localparam int DATA_W   = 16;
  localparam int REG_W    = 4;
  localparam int NUM_REGS = 16;
  localparam int TAG_W    = 3;

  localparam logic [TAG_W-1:0] TAG_NONE = '0;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } result_t;

endpackage

// File: rtl/cdb_fifo.sv
// Per-FU result buffer: small circular FIFO of result_t entries with occupancy count.
module cdb_fifo
  import cdb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    push_i,
  input  logic    pop_i,
  input  result_t wdata_i,
  output result_t rdata_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  result_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/cdb_writeback.sv
// Tomasulo writeback: buffers FU results, round-robin arbitrates onto the CDB and
// writes the register file when the tag still owns its register. Optional CDB_WB_PERF_EN adds perf counters.
module cdb_writeback
  import cdb_pkg::*;
#(
  parameter int NUM_FU     = 3,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic [NUM_FU-1:0]        fu_valid_i,
  output logic [NUM_FU-1:0]        fu_ready_o,
  input  logic [NUM_FU*TAG_W-1:0]  fu_tag_i,
  input  logic [NUM_FU*DATA_W-1:0] fu_data_i,
  input  logic                     issue_en_i,
  input  logic [REG_W-1:0]         issue_reg_i,
  input  logic [TAG_W-1:0]         issue_tag_i,
  input  logic [REG_W-1:0]         q_reg_b_i,
  input  logic [REG_W-1:0]         q_reg_c_i,
  output logic [TAG_W-1:0]         q_tag_b_o,
  output logic [TAG_W-1:0]         q_tag_c_o,
  output logic                     store_o,
  output logic [REG_W-1:0]         reg_a_o,
  output logic [DATA_W-1:0]        data_in_o,
  output logic                     cdb_valid_o,
  output logic [TAG_W-1:0]         cdb_tag_o,
  output logic [DATA_W-1:0]        cdb_data_o
`ifdef CDB_WB_PERF_EN
  ,
  output logic [15:0]              perf_bcast_o,
  output logic [15:0]              perf_stall_o
`endif
);

  localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  result_t           fifo_head  [NUM_FU];
  result_t           fifo_wdata [NUM_FU];
  logic [NUM_FU-1:0] fifo_push, fifo_pop, fifo_full, fifo_empty;

  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              grant_vld;
  logic [IDX_W-1:0]  grant_idx;
  result_t           head;
  logic              match_vld;
  logic [REG_W-1:0]  match_idx;

  logic [TAG_W-1:0]  status_q [NUM_REGS];
  logic              store_q, cdb_valid_q;
  logic [REG_W-1:0]  reg_a_q;
  logic [DATA_W-1:0] data_in_q, cdb_data_q;
  logic [TAG_W-1:0]  cdb_tag_q;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
    // Tag 0 results are acknowledged but never buffered.
    assign fifo_wdata[i] = '{tag: fu_tag_i[i*TAG_W +: TAG_W], data: fu_data_i[i*DATA_W +: DATA_W]};
    assign fifo_push[i]  = fu_valid_i[i] && fu_ready_o[i] &&
                           (fu_tag_i[i*TAG_W +: TAG_W] != TAG_NONE);
    assign fifo_pop[i]   = grant_vld && (grant_idx == IDX_W'(i));
    assign fu_ready_o[i] = !fifo_full[i];

    cdb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clock_i),
      .rst_i   (reset_i),
      .push_i  (fifo_push[i]),
      .pop_i   (fifo_pop[i]),
      .wdata_i (fifo_wdata[i]),
      .rdata_o (fifo_head[i]),
      .full_o  (fifo_full[i]),
      .empty_o (fifo_empty[i])
    );
  end

  // Scan from highest offset down so the first non-empty FIFO at/after the pointer wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = NUM_FU - 1; k >= 0; k--) begin
      if (!fifo_empty[(int'(rr_ptr_q) + k) % NUM_FU]) begin
        grant_vld = 1'b1;
        grant_idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_FU);
      end
    end
  end

  assign head     = fifo_head[grant_idx];
  assign rr_ptr_d = (grant_idx == IDX_W'(NUM_FU - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    match_vld = 1'b0;
    match_idx = '0;
    for (int r = NUM_REGS - 1; r >= 0; r--) begin
      if (status_q[r] == head.tag) begin
        match_vld = 1'b1;
        match_idx = REG_W'(r);
      end
    end
  end

  // A same-edge issue is written after the clear so the new owner wins.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rr_ptr_q    <= '0;
      store_q     <= 1'b0;
      cdb_valid_q <= 1'b0;
      reg_a_q     <= '0;
      data_in_q   <= '0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      for (int r = 0; r < NUM_REGS; r++) status_q[r] <= TAG_NONE;
    end else begin
      cdb_valid_q <= grant_vld;
      store_q     <= grant_vld && match_vld;
      if (grant_vld) begin
        rr_ptr_q   <= rr_ptr_d;
        cdb_tag_q  <= head.tag;
        cdb_data_q <= head.data;
        if (match_vld) begin
          reg_a_q             <= match_idx;
          data_in_q           <= head.data;
          status_q[match_idx] <= TAG_NONE;
        end
      end
      if (issue_en_i) status_q[issue_reg_i] <= issue_tag_i;
    end
  end

  assign q_tag_b_o   = status_q[q_reg_b_i];
  assign q_tag_c_o   = status_q[q_reg_c_i];
  assign store_o     = store_q;
  assign reg_a_o     = reg_a_q;
  assign data_in_o   = data_in_q;
  assign cdb_valid_o = cdb_valid_q;
  assign cdb_tag_o   = cdb_tag_q;
  assign cdb_data_o  = cdb_data_q;

`ifdef CDB_WB_PERF_EN
  logic [15:0] perf_bcast_q, perf_stall_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      perf_bcast_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (cdb_valid_q && (perf_bcast_q != 16'hFFFF)) perf_bcast_q <= perf_bcast_q + 16'd1;
      if ((|(fu_valid_i & ~fu_ready_o)) && (perf_stall_q != 16'hFFFF))
        perf_stall_q <= perf_stall_q + 16'd1;
    end
  end

  assign perf_bcast_o = perf_bcast_q;
  assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_cdb_writeback.sv
// Bench for cdb_writeback: directed scenarios plus random traffic against a queue-based reference model.
module tb_cdb_writeback;
  import cdb_pkg::*;

  localparam int NF = 3;
  localparam int DEPTH = 2;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic [NF-1:0]      fu_valid;
  logic [NF-1:0]      fu_ready;
  logic [NF*3-1:0]    fu_tag;
  logic [NF*16-1:0]   fu_data;
  logic               issue_en;
  logic [3:0]         issue_reg;
  logic [2:0]         issue_tag;
  logic [3:0]         q_reg_b, q_reg_c;
  logic [2:0]         q_tag_b, q_tag_c;
  logic               store, cdb_valid;
  logic [3:0]         reg_a;
  logic [15:0]        data_in, cdb_data;
  logic [2:0]         cdb_tag;
`ifdef CDB_WB_PERF_EN
  logic [15:0]        perf_bcast, perf_stall;
  int                 m_bcast, m_stall;
`endif

  always #5 clock = ~clock;

  cdb_writeback #(.NUM_FU(NF), .FIFO_DEPTH(DEPTH)) dut (
    .clock_i     (clock),
    .reset_i     (reset),
    .fu_valid_i  (fu_valid),
    .fu_ready_o  (fu_ready),
    .fu_tag_i    (fu_tag),
    .fu_data_i   (fu_data),
    .issue_en_i  (issue_en),
    .issue_reg_i (issue_reg),
    .issue_tag_i (issue_tag),
    .q_reg_b_i   (q_reg_b),
    .q_reg_c_i   (q_reg_c),
    .q_tag_b_o   (q_tag_b),
    .q_tag_c_o   (q_tag_c),
    .store_o     (store),
    .reg_a_o     (reg_a),
    .data_in_o   (data_in),
    .cdb_valid_o (cdb_valid),
    .cdb_tag_o   (cdb_tag),
    .cdb_data_o  (cdb_data)
`ifdef CDB_WB_PERF_EN
    ,
    .perf_bcast_o(perf_bcast),
    .perf_stall_o(perf_stall)
`endif
  );

  // Reference model: one queue per FU holding {tag,data}, status as a plain array.
  int mq [NF][$];
  int m_status [16];
  int m_ptr;
  int m_valid, m_store, m_reg_a, m_data_in, m_tag, m_data;
  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NF; i++) mq[i].delete();
    for (int r = 0; r < 16; r++) m_status[r] = 0;
    m_ptr = 0; m_valid = 0; m_store = 0; m_reg_a = 0; m_data_in = 0; m_tag = 0; m_data = 0;
`ifdef CDB_WB_PERF_EN
    m_bcast = 0; m_stall = 0;
`endif
  endtask

  task automatic model_edge();
    int sz [NF];
    int g, e, t, d, r;
    if (reset) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NF; i++) sz[i] = mq[i].size();
`ifdef CDB_WB_PERF_EN
    if (m_valid != 0 && m_bcast < 16'hFFFF) m_bcast++;
    begin
      bit st = 0;
      for (int i = 0; i < NF; i++) if (fu_valid[i] && sz[i] >= DEPTH) st = 1;
      if (st && m_stall < 16'hFFFF) m_stall++;
    end
`endif
    g = -1;
    for (int k = 0; k < NF; k++)
      if (g < 0 && sz[(m_ptr + k) % NF] > 0) g = (m_ptr + k) % NF;
    if (g >= 0) begin
      e = mq[g].pop_front();
      t = e >> 16; d = e & 'hFFFF;
      m_valid = 1; m_tag = t; m_data = d;
      r = -1;
      for (int j = 0; j < 16; j++) if (r < 0 && m_status[j] == t) r = j;
      if (r >= 0) begin
        m_store = 1; m_reg_a = r; m_data_in = d; m_status[r] = 0;
      end else m_store = 0;
      m_ptr = (g + 1) % NF;
    end else begin
      m_valid = 0; m_store = 0;
    end
    for (int i = 0; i < NF; i++)
      if (fu_valid[i] && sz[i] < DEPTH && fu_tag[i*3 +: 3] != 0)
        mq[i].push_back((int'(fu_tag[i*3 +: 3]) << 16) | int'(fu_data[i*16 +: 16]));
    if (issue_en) m_status[issue_reg] = issue_tag;
  endtask

  task automatic tick();
    #1;
    for (int i = 0; i < NF; i++)
      chk($sformatf("fu_ready%0d", i), fu_ready[i], (mq[i].size() < DEPTH));
    chk("q_tag_b", q_tag_b, m_status[q_reg_b]);
    chk("q_tag_c", q_tag_c, m_status[q_reg_c]);
    @(posedge clock);
    model_edge();
    @(negedge clock);
    chk("cdb_valid", cdb_valid, m_valid);
    chk("store", store, m_store);
    chk("cdb_tag", cdb_tag, m_tag);
    chk("cdb_data", cdb_data, m_data);
    chk("reg_a", reg_a, m_reg_a);
    chk("data_in", data_in, m_data_in);
`ifdef CDB_WB_PERF_EN
    chk("perf_bcast", perf_bcast, m_bcast);
    chk("perf_stall", perf_stall, m_stall);
`endif
  endtask

  task automatic set_fu(input int i, input bit v, input int tag, input int data);
    fu_valid[i] = v;
    fu_tag[i*3 +: 3] = tag[2:0];
    fu_data[i*16 +: 16] = data[15:0];
  endtask

  task automatic idle();
    fu_valid = '0; issue_en = 1'b0;
  endtask

  task automatic issue(input int r, input int t);
    issue_en = 1'b1; issue_reg = r[3:0]; issue_tag = t[2:0];
  endtask

  task automatic do_reset();
    idle(); reset = 1'b1; tick(); reset = 1'b0;
  endtask

  initial begin
    fu_valid = '0; fu_tag = '0; fu_data = '0;
    issue_en = 1'b0; issue_reg = '0; issue_tag = '0;
    q_reg_b = '0; q_reg_c = '0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    model_reset();
    @(negedge clock);
    chk("rst_ready", fu_ready, 3'b111);
    chk("rst_valid", cdb_valid, 0);
    chk("rst_store", store, 0);
    chk("rst_reg_a", reg_a, 0);
    chk("rst_data_in", data_in, 0);
    chk("rst_cdb_tag", cdb_tag, 0);
    chk("rst_cdb_data", cdb_data, 0);
    reset = 1'b0;

    // basic writeback r3 <- tag 2
    issue(3, 2); tick(); idle();
    set_fu(0, 1, 2, 'h00AB); tick(); idle();
    chk("t1_lat_valid", cdb_valid, 0);
    tick();
    chk("t1_valid", cdb_valid, 1);
    chk("t1_tag", cdb_tag, 2);
    chk("t1_store", store, 1);
    chk("t1_reg_a", reg_a, 3);
    chk("t1_data_in", data_in, 'h00AB);
    q_reg_b = 3; #1;
    chk("t1_qtag", q_tag_b, 0);

    // WAW: stale tag broadcasts without store
    issue(5, 1); tick();
    issue(5, 4); tick(); idle();
    set_fu(1, 1, 1, 'h1111); tick(); idle();
    tick();
    chk("waw_valid", cdb_valid, 1);
    chk("waw_store", store, 0);
    chk("waw_data", cdb_data, 'h1111);
    q_reg_c = 5; #1;
    chk("waw_qtag", q_tag_c, 4);

    // three-way contention, two rounds
    do_reset();
    for (int rnd = 0; rnd < 2; rnd++) begin
      for (int i = 0; i < NF; i++) set_fu(i, 1, i + 1, 'h100 * (i + 1));
      tick(); idle();
      for (int k = 0; k < NF; k++) begin
        tick();
        chk("rr_tag", cdb_tag, k + 1);
        chk("rr_valid", cdb_valid, 1);
      end
      tick();
      chk("rr_idle", cdb_valid, 0);
    end

    // fill FU2 while others hold the pointer
    do_reset();
    set_fu(0, 1, 1, 'hA001); set_fu(1, 1, 2, 'hA002); tick();
    set_fu(0, 1, 4, 'hA004); set_fu(1, 0, 0, 0); set_fu(2, 1, 3, 'hA003); tick();
    set_fu(0, 0, 0, 0); set_fu(2, 1, 5, 'hA005); tick();
    chk("full_ready2", fu_ready[2], 0);
    set_fu(2, 1, 6, 'hA006); tick(); idle();
    chk("full_pop_tag", cdb_tag, 3);
    chk("full_ready2_back", fu_ready[2], 1);
    repeat (4) tick();

    // same-edge issue and clear of r7
    do_reset();
    issue(7, 3); tick(); idle();
    set_fu(0, 1, 3, 'h3333); tick(); idle();
    issue(7, 6); tick(); idle();
    chk("coll_store", store, 1);
    chk("coll_reg_a", reg_a, 7);
    chk("coll_data", data_in, 'h3333);
    q_reg_b = 7; #1;
    chk("coll_qtag", q_tag_b, 6);

    // reset with buffered results
    for (int i = 0; i < NF; i++) set_fu(i, 1, i + 1, 'hB000 + i);
    tick(); tick(); idle();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mid_rst_valid", cdb_valid, 0);
    chk("mid_rst_ready", fu_ready, 3'b111);
    chk("mid_rst_tag", cdb_tag, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mid_rst_quiet", cdb_valid, 0);
    end

    // random traffic
    for (int n = 0; n < 500; n++) begin
      idle();
      for (int i = 0; i < NF; i++)
        set_fu(i, ($urandom_range(0, 9) < 6), $urandom_range(0, 7), $urandom_range(0, 'hFFFF));
      if ($urandom_range(0, 9) < 3) begin
        int r, t;
        bit ok;
        r = $urandom_range(0, 15); t = $urandom_range(1, 7); ok = 1;
        for (int j = 0; j < 16; j++) if (j != r && m_status[j] == t) ok = 0;
        if (ok) issue(r, t);
      end
      q_reg_b = $urandom_range(0, 15);
      q_reg_c = $urandom_range(0, 15);
      reset = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 1'b0; idle();
    repeat (8) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/cdb_writeback.md
# cdb_writeback

Writer side of the Tomasulo register file interface: collects results from the functional units, arbitrates them onto the common data bus (CDB), and drives the register file's store port. A register status table (Qi) tracks which reservation-station tag owns each architectural register. A result is written back only if its tag still owns the destination register; later issues to the same register (WAW) override earlier ones. Sits between the functional units and the 16 × 16-bit register file; reservation stations snoop the CDB outputs.

## Interface
- NUM_FU, 3: number of functional-unit result sources
- TAG_W, 3: reservation-station tag width; tag 0 = "value in register file"
- FIFO_DEPTH, 2: result buffer entries per FU
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- fu_valid  in  NUM_FU  result offered by FU i
- fu_ready  out  NUM_FU  FU i buffer not full
- fu_tag  in  NUM_FU*TAG_W  result tag, FU i at slice i
- fu_data  in  NUM_FU*16  result value, FU i at slice i
- issue_en  in  1  issue stage claims a destination register
- issue_reg  in  4  destination register index
- issue_tag  in  TAG_W  owning tag (non-zero)
- q_reg_b, q_reg_c  in  4 each  status query indices
- q_tag_b, q_tag_c  out  TAG_W each  combinational Qi of queried register (0 = ready)
- store  out  1  register file write enable
- reg_a  out  4  register file write index
- data_in  out  16  register file write data
- cdb_valid  out  1  broadcast valid
- cdb_tag  out  TAG_W  broadcast tag
- cdb_data  out  16  broadcast value

## Operation
- Enqueue into FU i's FIFO when fu_valid[i] && fu_ready[i]. fu_ready[i] = registered count < FIFO_DEPTH; no same-cycle pop bypass.
- A handshake with fu_tag == 0 is consumed and discarded (no enqueue).
- Round-robin arbiter over non-empty FIFOs: the pointer starts at 0 and advances to grant+1 after each grant. At most one grant per cycle.
- In the grant cycle, compare the head tag against all 16 status entries (at most one match by construction).
- On the next edge: pop the head, load cdb_* with the head entry, and set cdb_valid = 1.
  - If a status entry matched: store = 1, reg_a = matching index, data_in = value, and that status entry is cleared to 0.
  - Otherwise: store = 0 and only the broadcast occurs.
- issue_en sets status[issue_reg] = issue_tag on the edge. If it targets the register being cleared on the same edge, the issue wins (status = issue_tag). The store still happens.
- q_tag_b/q_tag_c read the registered status table; there is no bypass of the same-edge issue or clear.
- If no FIFO is non-empty, cdb_valid and store are 0 in the next cycle. cdb_tag, cdb_data, reg_a and data_in hold their last values.

## Timing
- Reset values: fu_ready all 1; store, cdb_valid = 0; reg_a, data_in, cdb_tag, cdb_data = 0; all FIFOs empty; status all 0; RR pointer 0.
- Reset mid-operation discards all buffered results and pending tags.
- Latency: handshake at edge E0 → grant in cycle E0..E1 → cdb_valid/store high in cycle E1..E2 (if uncontended).
- Throughput: one broadcast per cycle. A FU contending with all others waits at most NUM_FU−1 grants.
- The register file consumes store/reg_a/data_in at edge E2.

## Configuration
- CDB_WB_PERF_EN defined: adds outputs perf_bcast (16, count of cdb_valid cycles) and perf_stall (16, count of cycles where any fu_valid[i] && !fu_ready[i]).
  - Both counters saturate at 0xFFFF and reset to 0.
- CDB_WB_PERF_EN undefined: the ports and counters do not exist.

## Structure
- Package cdb_pkg: DATA_W = 16, REG_W = 4, NUM_REGS = 16, TAG_NONE = 0, and the result entry struct {tag, data}.
- Sub-module cdb_fifo: FIFO_DEPTH-entry circular buffer with count, push/pop and full/empty flags; instantiated NUM_FU times.
- Arbiter, status table and output registers live in the top module.

## Test plan
- Reset, then issue r3 ← tag 2; FU0 returns tag 2, data 0x00AB → two cycles later cdb_valid = 1, cdb_tag = 2, store = 1, reg_a = 3, data_in = 0x00AB; q_tag(r3) returns 0 afterwards.
- WAW: issue r5 ← tag 1, then r5 ← tag 4; FU1 returns tag 1, data 0x1111 → cdb_valid = 1, store = 0; status[r5] stays 4.
- All three FUs offer a result in the same cycle (tags 1, 2, 3) → broadcasts in order FU0, FU1, FU2 on consecutive cycles; the next contention round starts at FU0 only after the pointer wraps.
- Fill FU2 with 2 results without draining (other FUs continuously granted) → fu_ready[2] = 0; a third offer is not accepted; ready returns 1 the cycle after a pop.
- Issue r7 ← tag 6 on the same edge that a tag-3 writeback to r7 clears it → store = 1 to r7, status[r7] = 6.
- Assert reset while FIFOs hold entries → next cycle all outputs are at reset values and no broadcast follows.
